// File: rtl/bp_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bp_pkg
// Description : Shared types, constants and PC field helpers for the
//               BTB + 2-bit direction counter branch predictor.
// Revision    : 1.0 - initial release
// ============================================================================
package bp_pkg;

  // Widest tag any legal configuration can need (IDX_W >= 1, 32-bit PC).
  localparam int unsigned TAG_MAX_W = 29;

  // Direction counter encodings.
  localparam logic [1:0] CTR_SNT = 2'd0;  // strongly not taken
  localparam logic [1:0] CTR_WNT = 2'd1;  // weakly not taken
  localparam logic [1:0] CTR_WT  = 2'd2;  // weakly taken
  localparam logic [1:0] CTR_ST  = 2'd3;  // strongly taken

  // One BTB entry. The tag field is sized for the widest configuration and
  // only the low TAG_W bits are ever written non-zero.
  typedef struct packed {
    logic                 valid;
    logic [TAG_MAX_W-1:0] tag;
    logic [29:0]          target;  // word address, byte offset implied 0
    logic [1:0]           ctr;
  } bp_entry_t;

  // Entry index: pc[idx_w+1:2], returned zero-extended.
  function automatic logic [31:0] pc_index(input logic [31:0] pc,
                                           input int unsigned idx_w);
    return (pc >> 2) & ((32'd1 << idx_w) - 32'd1);
  endfunction

  // Tag: pc[idx_w+tag_w+1:idx_w+2], returned zero-extended.
  function automatic logic [31:0] pc_tag(input logic [31:0] pc,
                                         input int unsigned idx_w,
                                         input int unsigned tag_w);
    return (pc >> (idx_w + 2)) & ((32'd1 << tag_w) - 32'd1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/sat_counter2.sv
`default_nettype none
// ============================================================================
// Module      : sat_counter2
// Description : Next-state function of a 2-bit saturating up/down counter.
// Revision    : 1.0 - initial release
// ============================================================================
module sat_counter2
  import bp_pkg::*;
(
  input  logic [1:0] i_ctr,
  input  logic       i_up,
  output logic [1:0] o_ctr
);

  // Step toward the requested direction, holding at the end stops.
  always_comb begin
    o_ctr = i_ctr;
    if (i_up) begin
      if (i_ctr != CTR_ST) o_ctr = i_ctr + 2'd1;
    end else begin
      if (i_ctr != CTR_SNT) o_ctr = i_ctr - 2'd1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/branch_predictor.sv
`default_nettype none
// ============================================================================
// Module      : branch_predictor
// Description : Direct-mapped BTB with 2-bit direction counters. Lookup is
//               combinational from registered state (no bypass); updates
//               from ID are written on the rising edge. Includes saturating
//               resolved-branch and mispredict counters.
// Revision    : 1.0 - initial release
// ============================================================================
module branch_predictor
  import bp_pkg::*;
#(
  parameter int unsigned ENTRIES  = 64,
  parameter int unsigned TAG_W    = 8,
  parameter int unsigned CNT_W    = 32,
  parameter logic [1:0]  INIT_CTR = 2'b10
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [31:0]      if_pc,
  output logic             pred_hit,
  output logic             pred_taken,
  output logic [31:0]      pred_target,
  input  logic             upd_valid,
  input  logic [31:0]      upd_pc,
  input  logic             upd_taken,
  input  logic [31:0]      upd_target,
  input  logic             upd_mispredict,
  input  logic             flush_all,
  output logic [CNT_W-1:0] cnt_branches,
  output logic [CNT_W-1:0] cnt_mispredicts
);

  localparam int unsigned IDX_W = $clog2(ENTRIES);

  bp_entry_t r_mem [ENTRIES];

  logic [CNT_W-1:0] r_cnt_br;
  logic [CNT_W-1:0] r_cnt_mp;

  // ---- lookup path ----------------------------------------------------------
  logic [IDX_W-1:0]     w_if_idx;
  logic [TAG_MAX_W-1:0] w_if_tag;
  bp_entry_t            w_if_entry;

  assign w_if_idx   = IDX_W'(pc_index(if_pc, IDX_W));
  assign w_if_tag   = TAG_MAX_W'(pc_tag(if_pc, IDX_W, TAG_W));
  assign w_if_entry = r_mem[w_if_idx];

  // Hit requires a valid entry whose stored tag matches the fetch PC.
  always_comb begin
    pred_hit    = w_if_entry.valid && (w_if_entry.tag == w_if_tag);
    pred_taken  = pred_hit && w_if_entry.ctr[1];
    pred_target = pred_taken ? {w_if_entry.target, 2'b00} : (if_pc + 32'd4);
  end

  // ---- update path ----------------------------------------------------------
  logic [IDX_W-1:0]     w_up_idx;
  logic [TAG_MAX_W-1:0] w_up_tag;
  bp_entry_t            w_up_entry;
  logic                 w_up_hit;
  logic [1:0]           w_up_ctr_nxt;
  logic                 w_unused_target_lsbs;

  assign w_up_idx   = IDX_W'(pc_index(upd_pc, IDX_W));
  assign w_up_tag   = TAG_MAX_W'(pc_tag(upd_pc, IDX_W, TAG_W));
  assign w_up_entry = r_mem[w_up_idx];
  assign w_up_hit   = w_up_entry.valid && (w_up_entry.tag == w_up_tag);

  // Targets are word aligned; the byte offset of the resolved target is dropped.
  assign w_unused_target_lsbs = ^upd_target[1:0];

  sat_counter2 u_sat_counter2 (
    .i_ctr (w_up_entry.ctr),
    .i_up  (upd_taken),
    .o_ctr (w_up_ctr_nxt)
  );

  // Entry array: async clear, flush drops valid bits (and any update), else
  // train on hit or allocate on a taken miss.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(ENTRIES); i++) begin
        r_mem[i] <= '0;
      end
    end else if (flush_all) begin
      for (int i = 0; i < int'(ENTRIES); i++) begin
        r_mem[i].valid <= 1'b0;
      end
    end else if (upd_valid) begin
      if (w_up_hit) begin
        r_mem[w_up_idx].ctr <= w_up_ctr_nxt;
        if (upd_taken) r_mem[w_up_idx].target <= upd_target[31:2];
      end else if (upd_taken) begin
        r_mem[w_up_idx].valid  <= 1'b1;
        r_mem[w_up_idx].tag    <= w_up_tag;
        r_mem[w_up_idx].target <= upd_target[31:2];
        r_mem[w_up_idx].ctr    <= INIT_CTR;
      end
    end
  end

  // ---- performance counters -------------------------------------------------
  // Saturating event counters; they keep counting through a flush.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_cnt_br <= '0;
      r_cnt_mp <= '0;
    end else begin
      if (upd_valid && (r_cnt_br != '1)) r_cnt_br <= r_cnt_br + CNT_W'(1);
      if (upd_valid && upd_mispredict && (r_cnt_mp != '1)) r_cnt_mp <= r_cnt_mp + CNT_W'(1);
    end
  end

  assign cnt_branches    = r_cnt_br;
  assign cnt_mispredicts = r_cnt_mp;

endmodule
`default_nettype wire

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Parametrised dynamic branch predictor: direct-mapped branch target buffer (BTB) plus 2-bit saturating direction counters.
- Sits beside the PC register and instruction memory in IF. IF looks it up combinationally; ID updates it when a branch/jump resolves.
- Replaces the fixed "predict not-taken, flush on taken" policy of the 5-stage pipeline.
- Adds saturating performance counters for resolved branches and mispredicts.

Parameters:
- ENTRIES, 64, number of BTB entries; power of two, >= 2; IDX_W = $clog2(ENTRIES).
- TAG_W, 8, tag bits stored per entry; IDX_W+2+TAG_W <= 32.
- CNT_W, 32, width of each performance counter.
- INIT_CTR, 2'b10, counter value written when an entry is allocated (weakly taken).

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- if_pc  in  32  fetch PC being looked up.
- pred_hit  out  1  valid entry with matching tag for if_pc.
- pred_taken  out  1  pred_hit and counter[1]==1.
- pred_target  out  32  stored target when pred_taken, else if_pc+4.
- upd_valid  in  1  ID resolved a control-transfer instruction this cycle.
- upd_pc  in  32  PC of the resolved instruction.
- upd_taken  in  1  actual direction (jumps always 1).
- upd_target  in  32  actual target address.
- upd_mispredict  in  1  ID detected a wrong prediction (direction or target); qualified by upd_valid.
- flush_all  in  1  synchronously invalidate every entry.
- cnt_branches  out  CNT_W  resolved-branch count.
- cnt_mispredicts  out  CNT_W  mispredict count.

Behaviour:
- Index = pc[IDX_W+1:2]; tag = pc[IDX_W+TAG_W+1:IDX_W+2]; pc[1:0] ignored.
- Per-entry state: valid, tag[TAG_W], target[30] (word address, low 2 bits implied 0), ctr[2].
- Lookup is purely combinational from the registered state; zero latency.
  - Miss: pred_hit=0, pred_taken=0, pred_target=if_pc+4.
- Update is registered on the rising clock edge when upd_valid=1 and flush_all=0.
  - Hit (valid and tag match): ctr increments if taken, decrements if not; saturates at 3 and 0. If taken, target is overwritten with upd_target.
  - Miss and taken: allocate. valid=1, tag written, target written, ctr=INIT_CTR. Any previous occupant is evicted.
  - Miss and not taken: no array change.
- Simultaneous lookup and update to the same index: lookup returns the pre-update value. No bypass.
- flush_all=1: all valid bits cleared at the edge. A concurrent update is dropped. Counters are unaffected.
- Performance counters:
  - cnt_branches increments when upd_valid=1.
  - cnt_mispredicts increments when upd_valid && upd_mispredict.
  - Both saturate at all-ones and do not wrap.
  - Both count even when flush_all=1.
- Reset (reset=0, asynchronous, any time including mid-update):
  - All valid bits are 0 and both counters are 0.
  - tag, target and ctr may be cleared to 0 (preferred, for deterministic X-free simulation).
  - Therefore pred_hit=0, pred_taken=0, pred_target=if_pc+4 while reset is asserted and after it releases.
  - Release is clean: the first update on the first clock edge after release is accepted.
- No stall input. A held if_pc (pc_write=0) simply repeats the lookup, with no side effects.
- X on if_pc must not corrupt state; only the update path writes.

Decomposition:
- Shared package bp_pkg:
  - bp_entry_t struct (valid, tag, target, ctr).
  - Constants CTR_SNT=0, CTR_WNT=1, CTR_WT=2, CTR_ST=3.
  - Index/tag extraction functions.
- One natural sub-module: sat_counter2, a 2-bit saturating up/down next-state function. It is instantiated per update path, not per entry.
- Performance counters are inline.

Test Plan:
- Reset: hold reset=0, drive if_pc=0x0040_0010 -> pred_hit=0, pred_target=0x0040_0014; cnt_branches=0 and cnt_mispredicts=0.
- Allocate and predict: update upd_pc=0x0040_0020, taken=1, target=0x0040_0100. Next cycle look up 0x0040_0020 -> pred_hit=1, pred_taken=1 (ctr=2), pred_target=0x0040_0100.
- Saturation: 3 taken updates on the same PC -> ctr=3. Then 1 not-taken -> ctr=2, still predicted taken. A second not-taken -> ctr=1, pred_taken=0, pred_target=pc+4.
- Alias eviction (ENTRIES=64): allocate 0x0040_0020, then taken-update 0x0040_0120 (same index, different tag) -> lookup of 0x0040_0020 misses; lookup of 0x0040_0120 hits. A not-taken update on a miss leaves the entry unchanged.
- Same-cycle lookup/update and flush:
  - Lookup and update at the same index in one cycle -> old value returned that cycle, new value the next cycle.
  - flush_all together with a taken update -> all lookups miss afterwards, and cnt_branches still increments.
- Counter saturation (CNT_W=4): 20 cycles of upd_valid=1, upd_mispredict=1 -> both counters stop at 15. Then assert reset mid-run -> both read 0 immediately, without waiting for a clock edge.
